// File: rtl/bram_sdp_be.sv
// Simple-dual-port block RAM with per-byte write enables, selectable collision mode and read-valid.
// Define BRAM_SDP_OUT_REG_EN to add an output register stage (read latency 2 instead of 1).
module bram_sdp_be #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 9,
   parameter int unsigned BYTE_WIDTH = 8,
   parameter int unsigned WRITE_MODE = 0,
   localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_ea,
   input  logic [NUM_BYTES-1:0]  wr_be,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  rd_ea,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] douta,
   output logic                  rd_valid
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   if ((WRITE_MODE > 1) || ((DATA_WIDTH % BYTE_WIDTH) != 0)) begin : g_bad_cfg
      $error("bram_sdp_be: illegal WRITE_MODE or DATA_WIDTH not a multiple of BYTE_WIDTH");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] mem_rd_q;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  valid1_q;
   logic                  byp_hit_q;
   logic [NUM_BYTES-1:0]  byp_be_q;
   logic [DATA_WIDTH-1:0] byp_data_q;

   always_ff @(posedge clk) begin
      if (wr_ea) begin
         for (int unsigned i = 0; i < NUM_BYTES; i++) begin
            if (wr_be[i]) begin
               mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   // Unreset read latch keeps the storage mappable onto vendor block RAM.
   always_ff @(posedge clk) begin
      if (rd_ea) begin
         mem_rd_q <= mem[rd_addr];
      end
   end

   // Bypass registers only move on accepted reads so the merged word holds between reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid1_q   <= 1'b0;
         byp_hit_q  <= 1'b0;
         byp_be_q   <= '0;
         byp_data_q <= '0;
      end else begin
         valid1_q <= rd_ea;
         if (rd_ea) begin
            byp_hit_q  <= wr_ea && (wr_addr == rd_addr);
            byp_be_q   <= wr_be;
            byp_data_q <= data_in;
         end
      end
   end

   always_comb begin
      rd_word = mem_rd_q;
      if ((WRITE_MODE == 1) && byp_hit_q) begin
         for (int unsigned i = 0; i < NUM_BYTES; i++) begin
            if (byp_be_q[i]) begin
               rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = byp_data_q[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

`ifdef BRAM_SDP_OUT_REG_EN
   logic [DATA_WIDTH-1:0] douta_q;
   logic                  valid2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         douta_q  <= '0;
         valid2_q <= 1'b0;
      end else begin
         valid2_q <= valid1_q;
         if (valid1_q) begin
            douta_q <= rd_word;
         end
      end
   end

   assign douta    = douta_q;
   assign rd_valid = valid2_q;
`else
   // Masks the unreset read latch to zero until the first read after reset lands.
   logic have_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         have_q <= 1'b0;
      end else if (rd_ea) begin
         have_q <= 1'b1;
      end
   end

   assign douta    = have_q ? rd_word : '0;
   assign rd_valid = valid1_q;
`endif

endmodule

// File: tb/tb_bram_sdp_be.sv
// Scoreboard bench for bram_sdp_be: one READ_FIRST and one WRITE_FIRST instance share stimulus.
// Honours BRAM_SDP_OUT_REG_EN for the expected read latency.
module tb_bram_sdp_be;

   localparam int DW = 16;
   localparam int AW = 9;
   localparam int NB = 2;
`ifdef BRAM_SDP_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_ea = 1'b0;
   logic [NB-1:0] wr_be = '0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] data_in = '0;
   logic          rd_ea = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic [DW-1:0] douta0, douta1;
   logic          rd_valid0, rd_valid1;

   bram_sdp_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8), .WRITE_MODE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .wr_ea(wr_ea), .wr_be(wr_be), .wr_addr(wr_addr),
      .data_in(data_in), .rd_ea(rd_ea), .rd_addr(rd_addr), .douta(douta0), .rd_valid(rd_valid0)
   );

   bram_sdp_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8), .WRITE_MODE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .wr_ea(wr_ea), .wr_be(wr_be), .wr_addr(wr_addr),
      .data_in(data_in), .rd_ea(rd_ea), .rd_addr(rd_addr), .douta(douta1), .rd_valid(rd_valid1)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   n_checks = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops one expectation per rd_valid pulse, checking data and arrival cycle.
   always @(negedge clk) begin
      exp_t e;
      if (rd_valid0) begin
         if (q0.size() == 0) begin
            check_int("spurious_valid_mode0", int'(rd_valid0), 0);
         end else begin
            e = q0.pop_front();
            check("data_mode0", douta0, e.data);
            check_int("latency_mode0", cyc, e.due);
         end
      end
      if (rd_valid1) begin
         if (q1.size() == 0) begin
            check_int("spurious_valid_mode1", int'(rd_valid1), 0);
         end else begin
            e = q1.pop_front();
            check("data_mode1", douta1, e.data);
            check_int("latency_mode1", cyc, e.due);
         end
      end
   end

   // Drives one cycle of stimulus starting just after a rising edge; returns just after the next.
   task automatic cycle(input logic wr, input logic [NB-1:0] be, input logic [AW-1:0] waddr,
                        input logic [DW-1:0] din, input logic rd, input logic [AW-1:0] raddr,
                        input logic [DW-1:0] exp0, input logic [DW-1:0] exp1);
      exp_t e;
      wr_ea   = wr;
      wr_be   = be;
      wr_addr = waddr;
      data_in = din;
      rd_ea   = rd;
      rd_addr = raddr;
      if (rd) begin
         e.due  = cyc + LAT;
         e.data = exp0;
         q0.push_back(e);
         e.data = exp1;
         q1.push_back(e);
      end
      @(posedge clk);
      #1;
      wr_ea = 1'b0;
      wr_be = '0;
      rd_ea = 1'b0;
   endtask

   initial begin
      // Reset held with a read requested: outputs must stay at zero.
      rst_n   = 1'b0;
      rd_ea   = 1'b1;
      rd_addr = 9'd5;
      repeat (4) begin
         @(negedge clk);
         check("reset_douta_mode0", douta0, '0);
         check("reset_douta_mode1", douta1, '0);
         check_int("reset_valid_mode0", int'(rd_valid0), 0);
         check_int("reset_valid_mode1", int'(rd_valid1), 0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      rd_ea = 1'b0;

      // Write then read on the following edge.
      cycle(1'b1, 2'b11, 9'd5, 16'hA5A5, 1'b0, 9'd0, 16'h0, 16'h0);
      cycle(1'b0, 2'b00, 9'd0, 16'h0, 1'b1, 9'd5, 16'hA5A5, 16'hA5A5);

      // Byte enables, including an all-lanes-off write.
      cycle(1'b1, 2'b11, 9'd3, 16'h1234, 1'b0, 9'd0, 16'h0, 16'h0);
      cycle(1'b1, 2'b01, 9'd3, 16'hABCD, 1'b0, 9'd0, 16'h0, 16'h0);
      cycle(1'b1, 2'b00, 9'd3, 16'h5555, 1'b0, 9'd0, 16'h0, 16'h0);
      cycle(1'b0, 2'b00, 9'd0, 16'h0, 1'b1, 9'd3, 16'h12CD, 16'h12CD);

      // Collision: READ_FIRST returns old word, WRITE_FIRST returns merged word.
      cycle(1'b1, 2'b11, 9'd7, 16'h0001, 1'b0, 9'd0, 16'h0, 16'h0);
      cycle(1'b1, 2'b10, 9'd7, 16'hFFFF, 1'b1, 9'd7, 16'h0001, 16'hFF01);
      cycle(1'b0, 2'b00, 9'd0, 16'h0, 1'b1, 9'd7, 16'hFF01, 16'hFF01);

      // Simultaneous write and read at different addresses.
      cycle(1'b1, 2'b11, 9'd8, 16'h7777, 1'b1, 9'd3, 16'h12CD, 16'h12CD);

      // Fill then stream every address back-to-back.
      for (int i = 0; i < 512; i++) begin
         cycle(1'b1, 2'b11, AW'(i), DW'(i), 1'b0, 9'd0, 16'h0, 16'h0);
      end
      for (int i = 0; i < 512; i++) begin
         cycle(1'b0, 2'b00, 9'd0, 16'h0, 1'b1, AW'(i), DW'(i), DW'(i));
      end
      repeat (LAT + 2) @(posedge clk);
      #1;

      // douta holds the last delivered word while idle.
      @(negedge clk);
      check("hold_douta_mode0", douta0, 16'h01FF);
      check("hold_douta_mode1", douta1, 16'h01FF);
      @(posedge clk);
      #1;

      // Reset while two reads are in flight: their valids must never appear.
      cycle(1'b0, 2'b00, 9'd0, 16'h0, 1'b1, 9'd20, 16'h0014, 16'h0014);
      cycle(1'b0, 2'b00, 9'd0, 16'h0, 1'b1, 9'd21, 16'h0015, 16'h0015);
      rst_n = 1'b0;
      q0.delete();
      q1.delete();
      @(negedge clk);
      check_int("midreset_valid_mode0", int'(rd_valid0), 0);
      check_int("midreset_valid_mode1", int'(rd_valid1), 0);
      check("midreset_douta_mode0", douta0, '0);
      check("midreset_douta_mode1", douta1, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Memory survives reset.
      cycle(1'b0, 2'b00, 9'd0, 16'h0, 1'b1, 9'd10, 16'h000A, 16'h000A);
      repeat (LAT + 3) @(posedge clk);
      #1;

      check_int("pending_mode0", q0.size(), 0);
      check_int("pending_mode1", q1.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
